// File: rtl/decapsulator.sv
// Receive-side trace decapsulator: rebuilds header/srcid/timestamp/payload from a byte stream.
// Optional source-ID byte after the header is enabled by defining ENCAP_SRCID_EN.
module decapsulator #(
    parameter int unsigned TS_BYTES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    byte_valid_i,
    input  logic [7:0]              byte_i,
    output logic                    byte_ready_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [4:0]              packet_length_o,
    output logic [1:0]              flow_o,
    output logic                    timestamp_present_o,
    output logic [8*TS_BYTES-1:0]   timestamp_o,
    output logic [247:0]            trace_payload_o,
`ifdef ENCAP_SRCID_EN
    output logic [7:0]              srcid_o,
`endif
    output logic                    null_o
);

    localparam int unsigned TsCntW = $clog2(TS_BYTES + 1);

`ifdef ENCAP_SRCID_EN
    typedef enum logic [2:0] {
        StHeader    = 3'd0,
        StSrcid     = 3'd1,
        StTimestamp = 3'd2,
        StPayload   = 3'd3,
        StOutput    = 3'd4
    } state_e;
`else
    typedef enum logic [2:0] {
        StHeader    = 3'd0,
        StTimestamp = 3'd2,
        StPayload   = 3'd3,
        StOutput    = 3'd4
    } state_e;
`endif

    state_e                state_q, state_d;
    logic [4:0]            len_q, len_d;
    logic [1:0]            flow_q, flow_d;
    logic                  ext_q, ext_d;
    logic [8*TS_BYTES-1:0] ts_q, ts_d;
    logic [247:0]          payload_q, payload_d;
    logic [TsCntW-1:0]     ts_cnt_q, ts_cnt_d;
    logic [4:0]            pay_cnt_q, pay_cnt_d;
    logic                  null_q, null_d;
`ifdef ENCAP_SRCID_EN
    logic [7:0]            srcid_q, srcid_d;
`endif

    logic xfer;

    assign byte_ready_o = !rst_i && (state_q != StOutput);
    assign xfer         = byte_valid_i && byte_ready_o;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        flow_d    = flow_q;
        ext_d     = ext_q;
        ts_d      = ts_q;
        payload_d = payload_q;
        ts_cnt_d  = ts_cnt_q;
        pay_cnt_d = pay_cnt_q;
        null_d    = 1'b0;
`ifdef ENCAP_SRCID_EN
        srcid_d   = srcid_q;
`endif
        case (state_q)
            StHeader: begin
                if (xfer) begin
                    len_d     = byte_i[4:0];
                    flow_d    = byte_i[6:5];
                    ext_d     = byte_i[7];
                    ts_d      = '0;
                    payload_d = '0;
                    ts_cnt_d  = '0;
                    pay_cnt_d = '0;
                    // Zero-length header is a null packet: nothing follows it, even with extend set.
                    if (byte_i[4:0] == 5'd0) begin
                        null_d = 1'b1;
                    end else begin
`ifdef ENCAP_SRCID_EN
                        state_d = StSrcid;
`else
                        state_d = byte_i[7] ? StTimestamp : StPayload;
`endif
                    end
                end
            end
`ifdef ENCAP_SRCID_EN
            StSrcid: begin
                if (xfer) begin
                    srcid_d = byte_i;
                    state_d = ext_q ? StTimestamp : StPayload;
                end
            end
`endif
            StTimestamp: begin
                if (xfer) begin
                    for (int unsigned k = 0; k < TS_BYTES; k++) begin
                        if (ts_cnt_q == TsCntW'(k)) begin
                            ts_d[8*k +: 8] = byte_i;
                        end
                    end
                    if (ts_cnt_q == TsCntW'(TS_BYTES - 1)) begin
                        ts_cnt_d = '0;
                        state_d  = StPayload;
                    end else begin
                        ts_cnt_d = ts_cnt_q + 1'b1;
                    end
                end
            end
            StPayload: begin
                if (xfer) begin
                    for (int unsigned k = 0; k < 31; k++) begin
                        if (pay_cnt_q == 5'(k)) begin
                            payload_d[8*k +: 8] = byte_i;
                        end
                    end
                    if (pay_cnt_q == len_q - 5'd1) begin
                        pay_cnt_d = '0;
                        state_d   = StOutput;
                    end else begin
                        pay_cnt_d = pay_cnt_q + 5'd1;
                    end
                end
            end
            StOutput: begin
                if (ready_i) begin
                    state_d = StHeader;
                end
            end
            default: begin
                state_d = StHeader;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StHeader;
            len_q     <= '0;
            flow_q    <= '0;
            ext_q     <= 1'b0;
            ts_q      <= '0;
            payload_q <= '0;
            ts_cnt_q  <= '0;
            pay_cnt_q <= '0;
            null_q    <= 1'b0;
`ifdef ENCAP_SRCID_EN
            srcid_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            flow_q    <= flow_d;
            ext_q     <= ext_d;
            ts_q      <= ts_d;
            payload_q <= payload_d;
            ts_cnt_q  <= ts_cnt_d;
            pay_cnt_q <= pay_cnt_d;
            null_q    <= null_d;
`ifdef ENCAP_SRCID_EN
            srcid_q   <= srcid_d;
`endif
        end
    end

    assign valid_o             = (state_q == StOutput);
    assign packet_length_o     = len_q;
    assign flow_o              = flow_q;
    assign timestamp_present_o = ext_q;
    assign timestamp_o         = ts_q;
    assign trace_payload_o     = payload_q;
    assign null_o              = null_q;
`ifdef ENCAP_SRCID_EN
    assign srcid_o             = srcid_q;
`endif

endmodule
